ram_burst_tracker: RTL and testbench
====================================

RAM_BURST_TRACKER -- requirements
Module: ram_burst_tracker

Interface
REQ-001 Parameter LATENCY, default 3: number of filtered clock strobes skipped between the address strobe and the first data word.
REQ-002 Parameter BURST_MAX, default 128: maximum number of words emitted per burst.
REQ-003 Port mclk, input, 1: system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port filter_a, input, 23: filtered RAM address.
REQ-006 Port filter_d, input, 16: filtered RAM data.
REQ-007 Port filter_ublb, input, 2: filtered byte enables {ub, lb}, positive logic.
REQ-008 Ports filter_read, filter_write, filter_addr_latch, each input, 1: filtered positive-logic control.
REQ-009 Port filter_strobe, input, 1: one-cycle pulse; the filter_* inputs are valid only when it is high.
REQ-010 Port out_valid, output, 1: output word available.
REQ-011 Port out_ready, input, 1: consumer accepts the word when out_valid && out_ready.
REQ-012 Ports out_addr (23), out_data (16), out_ublb (2), out_write (1), outputs: head word fields; out_write=1 for a write, 0 for a read.
REQ-013 Port overflow_count, output, 8: count of dropped words, saturating.

Function
REQ-014 The block shall act only on cycles where filter_strobe=1; all other cycles leave the FSM, counters and address unchanged.
REQ-015 The FSM shall have three states: IDLE, WAIT, DATA.
REQ-016 In any state, a strobe with filter_addr_latch=1 shall load cur_addr<=filter_a, clear word_cnt, load wait_cnt<=LATENCY, and go to WAIT; if LATENCY=0 it shall go directly to DATA. No word is emitted on this strobe.
REQ-017 In WAIT, each strobe without addr_latch shall decrement wait_cnt; the strobe that decrements it from 1 to 0 shall move to DATA. No word is emitted in WAIT.
REQ-018 In DATA, a strobe with addr_latch=0 and (filter_read || filter_write) shall emit one word {cur_addr, filter_d, filter_ublb, filter_write}, then cur_addr<=cur_addr+1 mod 2^23 (0x7FFFFF wraps to 0x000000) and word_cnt<=word_cnt+1.
REQ-019 If read and write are both high on a data strobe, the word shall be emitted with out_write=1.
REQ-020 In DATA, a strobe with addr_latch=0, read=0 and write=0 shall return to IDLE without emitting.
REQ-021 The strobe emitting word number BURST_MAX shall emit it and return to IDLE.
REQ-022 In IDLE, strobes without addr_latch shall be ignored.
REQ-023 The output buffer shall be a 2-entry FIFO; out_valid=1 iff the FIFO is non-empty, and the out_* fields shall show the oldest entry.
REQ-024 Push-to-out_valid latency shall be one mclk cycle: the word is visible on the cycle after the emitting strobe.
REQ-025 When push and pop occur in the same cycle with the FIFO full, the push shall be accepted.
REQ-026 When push occurs with the FIFO full and no pop, the word shall be dropped, overflow_count shall increment, and the FSM and address shall still advance.
REQ-027 overflow_count shall saturate at 255.
REQ-028 out_* fields shall be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 Reset shall asynchronously force: state IDLE; cur_addr, wait_cnt and word_cnt 0; FIFO empty (out_valid=0); out_addr, out_data, out_ublb, out_write 0; overflow_count 0.
REQ-030 Reset asserted mid-burst shall discard buffered words; after release, data strobes shall be ignored until the next addr_latch strobe.

Verification
REQ-031 Basic read burst: LATENCY=3, out_ready=1; addr strobe filter_a=0x001000, 3 wait strobes, 4 read strobes with d=0xA0..0xA3, then an idle strobe -> 4 words at addrs 0x1000..0x1003, data 0xA0..0xA3, out_write=0; FSM ends in IDLE.
REQ-032 Address wrap: addr 0x7FFFFE, LATENCY=0, 3 write strobes -> addrs 0x7FFFFE, 0x7FFFFF, 0x000000, all with out_write=1.
REQ-033 Back-pressure: out_ready=0 with 5 data strobes -> first 2 words retained in order, overflow_count=3; after 300 further dropped words, overflow_count=255.
REQ-034 Simultaneous push/pop: FIFO full, out_ready=1 on the cycle a new word is emitted -> no drop, overflow_count unchanged, order preserved.
REQ-035 Burst limit and restart: BURST_MAX=4, 6 data strobes -> exactly 4 words emitted; an addr_latch strobe arriving in WAIT or DATA restarts the burst at the new address with a full LATENCY wait.
REQ-036 Reset mid-burst: reset pulsed after 2 of 4 data words -> out_valid=0 and overflow_count=0 immediately; after release, subsequent read strobes emit nothing until the next addr_latch strobe.

Source files
------------

// File: rtl/ram_burst_tracker.sv
// rtl/ram_burst_tracker.sv - tracks filtered RAM strobes into address/data bursts buffered in a 2-entry FIFO
module ram_burst_tracker #(
  parameter int LATENCY   = 3,
  parameter int BURST_MAX = 128
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [22:0] filter_a,
  input  logic [15:0] filter_d,
  input  logic [1:0]  filter_ublb,
  input  logic        filter_read,
  input  logic        filter_write,
  input  logic        filter_addr_latch,
  input  logic        filter_strobe,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] out_addr,
  output logic [15:0] out_data,
  output logic [1:0]  out_ublb,
  output logic        out_write,
  output logic [7:0]  overflow_count
);

  localparam int WW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int CW = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  state_t          state;
  logic [22:0]     cur_addr;
  logic [WW-1:0]   wait_cnt;
  logic [CW-1:0]   word_cnt;

  logic [41:0]     head;
  logic [41:0]     tail;
  logic [1:0]      count;

  logic            push;
  logic            pop;
  logic [41:0]     push_word;

  assign push = filter_strobe && !filter_addr_latch && (state == DATA)
                && (filter_read || filter_write);
  assign pop  = (count != 2'd0) && out_ready;
  // filter_write alone selects the direction, so read+write reports as a write
  assign push_word = {cur_addr, filter_d, filter_ublb, filter_write};

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      wait_cnt <= '0;
      word_cnt <= '0;
    end else if (filter_strobe) begin
      if (filter_addr_latch) begin
        cur_addr <= filter_a;
        word_cnt <= '0;
        wait_cnt <= WW'(LATENCY);
        state    <= (LATENCY == 0) ? DATA : WAIT;
      end else begin
        case (state)
          WAIT: begin
            wait_cnt <= wait_cnt - WW'(1);
            if (wait_cnt == WW'(1)) state <= DATA;
          end
          DATA: begin
            if (push) begin
              cur_addr <= cur_addr + 23'd1;
              word_cnt <= word_cnt + CW'(1);
              if (word_cnt == CW'(BURST_MAX - 1)) state <= IDLE;
            end else begin
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // head is always the oldest entry; a pop shifts tail forward
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      overflow_count <= '0;
    end else begin
      if (push && !pop && (count == 2'd2) && (overflow_count != 8'hFF))
        overflow_count <= overflow_count + 8'd1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_word;
          else if (count == 2'd1) tail <= push_word;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_word;
          end else begin
            head <= tail;
            tail <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign {out_addr, out_data, out_ublb, out_write} = head;

endmodule

// File: tb/tb_ram_burst_tracker.sv
// tb/tb_ram_burst_tracker.sv - self-checking bench for ram_burst_tracker with a queue-based reference model
module tb_ram_burst_tracker;

  logic        mclk;
  logic        reset;
  logic [22:0] filter_a;
  logic [15:0] filter_d;
  logic [1:0]  filter_ublb;
  logic        filter_read, filter_write, filter_addr_latch, filter_strobe;
  logic        out_ready;

  logic        a_valid, a_write, b_valid, b_write;
  logic [22:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [1:0]  a_ublb, b_ublb;
  logic [7:0]  a_ovf, b_ovf;
  logic [41:0] a_word, b_word;

  assign a_word = {a_addr, a_data, a_ublb, a_write};
  assign b_word = {b_addr, b_data, b_ublb, b_write};

  ram_burst_tracker #(.LATENCY(3), .BURST_MAX(128)) dut_a (
    .mclk(mclk), .reset(reset), .filter_a(filter_a), .filter_d(filter_d),
    .filter_ublb(filter_ublb), .filter_read(filter_read), .filter_write(filter_write),
    .filter_addr_latch(filter_addr_latch), .filter_strobe(filter_strobe),
    .out_valid(a_valid), .out_ready(out_ready), .out_addr(a_addr), .out_data(a_data),
    .out_ublb(a_ublb), .out_write(a_write), .overflow_count(a_ovf));

  ram_burst_tracker #(.LATENCY(0), .BURST_MAX(4)) dut_b (
    .mclk(mclk), .reset(reset), .filter_a(filter_a), .filter_d(filter_d),
    .filter_ublb(filter_ublb), .filter_read(filter_read), .filter_write(filter_write),
    .filter_addr_latch(filter_addr_latch), .filter_strobe(filter_strobe),
    .out_valid(b_valid), .out_ready(out_ready), .out_addr(b_addr), .out_data(b_data),
    .out_ublb(b_ublb), .out_write(b_write), .overflow_count(b_ovf));

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: one burst context per instance, FIFO as a bounded queue
  int          lat[2];
  int          bm[2];
  bit          armed[2];
  int          wt[2];
  int          nw[2];
  logic [22:0] ad[2];
  int          movf[2];
  logic [41:0] mq0[$];
  logic [41:0] mq1[$];
  logic [41:0] alog[$];
  logic [41:0] blog[$];

  function automatic logic [41:0] mkw(input logic [22:0] a, input logic [15:0] d,
                                      input logic [1:0] ub, input logic wr);
    return {a, d, ub, wr};
  endfunction

  function automatic int qsz(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      armed[i] = 0; wt[i] = 0; nw[i] = 0; ad[i] = '0; movf[i] = 0;
    end
    mq0.delete(); mq1.delete();
  endtask

  task automatic model_step(input int i);
    logic [41:0] w;
    bit push, pop;
    push = 0;
    w = '0;
    pop = (qsz(i) > 0) && out_ready;
    if (filter_strobe) begin
      if (filter_addr_latch) begin
        ad[i] = filter_a; nw[i] = 0; wt[i] = lat[i]; armed[i] = 1;
      end else if (armed[i] && wt[i] > 0) begin
        wt[i]--;
      end else if (armed[i]) begin
        if (filter_read || filter_write) begin
          w = mkw(ad[i], filter_d, filter_ublb, filter_write);
          push = 1;
          ad[i] = ad[i] + 23'd1;
          nw[i]++;
          if (nw[i] >= bm[i]) armed[i] = 0;
        end else begin
          armed[i] = 0;
        end
      end
    end
    if (pop) begin
      if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    end
    if (push) begin
      if (qsz(i) < 2) begin
        if (i == 0) mq0.push_back(w); else mq1.push_back(w);
      end else if (movf[i] < 255) begin
        movf[i]++;
      end
    end
  endtask

  task automatic check_all();
    chk("a_valid", a_valid, mq0.size() > 0);
    chk("a_ovf", a_ovf, movf[0]);
    if (mq0.size() > 0) chk("a_head", a_word, mq0[0]);
    chk("b_valid", b_valid, mq1.size() > 0);
    chk("b_ovf", b_ovf, movf[1]);
    if (mq1.size() > 0) chk("b_head", b_word, mq1[0]);
  endtask

  task automatic cyc();
    if (a_valid && out_ready) alog.push_back(a_word);
    if (b_valid && out_ready) blog.push_back(b_word);
    model_step(0);
    model_step(1);
    @(posedge mclk);
    #1;
    check_all();
  endtask

  // one strobe cycle followed by a non-strobe cycle carrying garbage on the filter bus
  task automatic strobe(input logic latch, input logic rd, input logic wr,
                        input logic [22:0] a, input logic [15:0] d);
    filter_strobe = 1; filter_addr_latch = latch; filter_read = rd; filter_write = wr;
    filter_a = a; filter_d = d; filter_ublb = 2'b11;
    cyc();
    filter_strobe = 0; filter_addr_latch = 1'($urandom);
    filter_read = 1'($urandom); filter_write = 1'($urandom);
    filter_a = 23'($urandom); filter_d = 16'($urandom); filter_ublb = 2'($urandom);
    cyc();
  endtask

  task automatic idle(input int n);
    filter_strobe = 0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    lat[0] = 3; bm[0] = 128; lat[1] = 0; bm[1] = 4;
    reset = 1; out_ready = 0;
    filter_a = '0; filter_d = '0; filter_ublb = '0;
    filter_read = 0; filter_write = 0; filter_addr_latch = 0; filter_strobe = 0;
    model_reset();
    @(posedge mclk); #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_word", a_word, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_word", b_word, 0);
    reset = 0;

    // basic read burst
    out_ready = 1; alog.delete();
    strobe(1, 0, 0, 23'h001000, 0);
    for (int k = 0; k < 3; k++) strobe(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) strobe(0, 1, 0, 0, 16'(16'hA0 + k));
    strobe(0, 0, 0, 0, 0);
    strobe(0, 1, 0, 0, 16'h55);
    idle(4);
    chk("r031_cnt", alog.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("r031_word", alog[k], mkw(23'(23'h1000 + k), 16'(16'hA0 + k), 2'b11, 1'b0));

    // address wrap on the zero-latency instance
    blog.delete();
    strobe(1, 0, 0, 23'h7FFFFE, 0);
    for (int k = 0; k < 3; k++) strobe(0, 0, 1, 0, 16'(16'hB0 + k));
    strobe(0, 0, 0, 0, 0);
    idle(4);
    chk("r032_cnt", blog.size(), 3);
    chk("r032_w0", blog[0], mkw(23'h7FFFFE, 16'hB0, 2'b11, 1'b1));
    chk("r032_w1", blog[1], mkw(23'h7FFFFF, 16'hB1, 2'b11, 1'b1));
    chk("r032_w2", blog[2], mkw(23'h000000, 16'hB2, 2'b11, 1'b1));

    // simultaneous push and pop into a full FIFO
    out_ready = 0; alog.delete();
    strobe(1, 0, 0, 23'h003000, 0);
    for (int k = 0; k < 3; k++) strobe(0, 0, 0, 0, 0);
    strobe(0, 1, 0, 0, 16'h1);
    strobe(0, 1, 1, 0, 16'h2);
    out_ready = 1;
    strobe(0, 1, 0, 0, 16'h3);
    strobe(0, 0, 0, 0, 0);
    idle(4);
    chk("r034_ovf", a_ovf, 0);
    chk("r034_cnt", alog.size(), 3);
    chk("r034_w0", alog[0], mkw(23'h3000, 16'h1, 2'b11, 1'b0));
    chk("r034_w1", alog[1], mkw(23'h3001, 16'h2, 2'b11, 1'b1));
    chk("r034_w2", alog[2], mkw(23'h3002, 16'h3, 2'b11, 1'b0));

    // back-pressure drops and saturation
    out_ready = 0; alog.delete();
    strobe(1, 0, 0, 23'h002000, 0);
    for (int k = 0; k < 3; k++) strobe(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) strobe(0, 1, 0, 0, 16'(16'hC0 + k));
    chk("r033_ovf3", a_ovf, 3);
    for (int r = 0; r < 3; r++) begin
      strobe(1, 0, 0, 23'h004000, 0);
      for (int k = 0; k < 3; k++) strobe(0, 0, 0, 0, 0);
      for (int k = 0; k < 100; k++) strobe(0, 1, 0, 0, 16'(k));
    end
    chk("r033_ovf_sat", a_ovf, 255);
    out_ready = 1;
    idle(4);
    chk("r033_cnt", alog.size(), 2);
    chk("r033_w0", alog[0], mkw(23'h2000, 16'hC0, 2'b11, 1'b0));
    chk("r033_w1", alog[1], mkw(23'h2001, 16'hC1, 2'b11, 1'b0));

    // burst limit on the BURST_MAX=4 instance
    blog.delete();
    strobe(1, 0, 0, 23'h000300, 0);
    for (int k = 0; k < 6; k++) strobe(0, 1, 0, 0, 16'(16'hD0 + k));
    idle(4);
    chk("r035_cnt", blog.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("r035_word", blog[k], mkw(23'(23'h300 + k), 16'(16'hD0 + k), 2'b11, 1'b0));

    // restart from WAIT needs a full latency wait again
    alog.delete();
    strobe(1, 0, 0, 23'h000500, 0);
    strobe(0, 1, 0, 0, 16'hE0);
    strobe(0, 1, 0, 0, 16'hE1);
    strobe(1, 0, 0, 23'h000600, 0);
    strobe(0, 0, 0, 0, 0);
    strobe(0, 0, 0, 0, 0);
    strobe(0, 1, 0, 0, 16'hE2);
    strobe(0, 1, 0, 0, 16'hE3);
    strobe(1, 0, 0, 23'h000700, 0);
    strobe(0, 0, 0, 0, 0);
    idle(4);
    chk("r035_restart_cnt", alog.size(), 1);
    chk("r035_restart_w", alog[0], mkw(23'h600, 16'hE3, 2'b11, 1'b0));

    // asynchronous reset mid-burst
    out_ready = 0;
    strobe(1, 0, 0, 23'h000800, 0);
    for (int k = 0; k < 3; k++) strobe(0, 0, 0, 0, 0);
    strobe(0, 1, 0, 0, 16'hF0);
    strobe(0, 1, 0, 0, 16'hF1);
    reset = 1;
    #2;
    chk("r036_a_valid", a_valid, 0);
    chk("r036_a_ovf", a_ovf, 0);
    chk("r036_b_valid", b_valid, 0);
    chk("r036_b_ovf", b_ovf, 0);
    model_reset();
    reset = 0;
    out_ready = 1; alog.delete();
    strobe(0, 1, 0, 0, 16'hF2);
    strobe(0, 1, 0, 0, 16'hF3);
    idle(2);
    chk("r036_ignored", alog.size(), 0);
    strobe(1, 0, 0, 23'h000900, 0);
    for (int k = 0; k < 3; k++) strobe(0, 0, 0, 0, 0);
    strobe(0, 1, 0, 0, 16'hF4);
    idle(4);
    chk("r036_resume_cnt", alog.size(), 1);
    chk("r036_resume_w", alog[0], mkw(23'h900, 16'hF4, 2'b11, 1'b0));

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      out_ready         = ($urandom_range(0, 3) != 0);
      filter_strobe     = 1'($urandom_range(0, 1));
      filter_addr_latch = ($urandom_range(0, 15) == 0);
      filter_read       = ($urandom_range(0, 3) != 0);
      filter_write      = ($urandom_range(0, 3) == 0);
      filter_a          = ($urandom_range(0, 1) == 1) ? 23'(23'h7FFFFC + $urandom_range(0, 3))
                                                      : 23'($urandom);
      filter_d          = 16'($urandom);
      filter_ublb       = 2'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
